painterengine_gpu_block_sequencer: RTL and testbench

Parametrised block sequencer for the PainterEngine GPU render path. It walks a rectangular render region in row-major order and splits each row into blocks of at most `BLOCK_PIXELS`. Per block, it computes source and destination addresses and drives the reader, writer and rasterizer channels. It sits between the register/CSR front end and the DMA reader/writer engines. Over a fixed single-shot walker it adds: start/busy/done handshake, configurable pixel size and block length, copy mode, rasterizer back-pressure, abort, and sticky error codes.

---
 rtl/painterengine_gpu_pkg.sv | 41 ++++
 rtl/painterengine_gpu_block_addr.sv | 52 +++++
 rtl/painterengine_gpu_block_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_painterengine_gpu_block_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_pkg.sv
// Shared definitions for the PainterEngine GPU block sequencer.
// Contents: 8-bit FSM state encodings (IDLE = 0x00), job mode codes,
// sticky error codes and a helper that identifies the non-busy states.
package painterengine_gpu_pkg;

    typedef enum logic [7:0] {
        ST_IDLE  = 8'h00,
        ST_CHECK = 8'h01,
        ST_ADDR0 = 8'h02,
        ST_ADDR1 = 8'h03,
        ST_GEN   = 8'h04,
        ST_READ1 = 8'h05,
        ST_READ2 = 8'h06,
        ST_WRITE = 8'h07,
        ST_NEXT  = 8'h08,
        ST_DONE  = 8'h09,
        ST_ERROR = 8'h0A
    } state_t;

    typedef enum logic [1:0] {
        MODE_BLEND   = 2'b00,
        MODE_RASTER  = 2'b01,
        MODE_COPY    = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_READER1 = 3'd1,
        ERR_READER2 = 3'd2,
        ERR_WRITER  = 3'd3,
        ERR_MODE    = 3'd4,
        ERR_ABORT   = 3'd5
    } err_t;

    // States in which a new start is accepted and busy is low.
    function automatic logic is_idle_like(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/painterengine_gpu_block_addr.sv
// Two-stage block address generator for the source and destination channels.
// Stage 0 (load_rows) registers the row offsets y*stride; stage 1 (load_addr)
// registers base + ((row_offset + x) << BPP_SHIFT), all modulo 2^ADDR_W.
// Ports: clk/reset (sync, active-high), load_rows, load_addr strobes,
// y/x position, per-channel strides and bases in; src_addr/dst_addr out.
module painterengine_gpu_block_addr #(
    parameter int unsigned COORD_W   = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BPP_SHIFT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_rows,
    input  logic               load_addr,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] src_stride,
    input  logic [COORD_W-1:0] dst_stride,
    input  logic [ADDR_W-1:0]  src_base,
    input  logic [ADDR_W-1:0]  dst_base,
    output logic [ADDR_W-1:0]  src_addr,
    output logic [ADDR_W-1:0]  dst_addr
);

    logic [2*COORD_W-1:0] ys_q, yd_q;
    logic [ADDR_W-1:0]    src_off, dst_off;

    // Products are zero-extended to the address width before the pixel shift.
    always_comb begin
        src_off = (ADDR_W'(ys_q) + ADDR_W'(x)) << BPP_SHIFT;
        dst_off = (ADDR_W'(yd_q) + ADDR_W'(x)) << BPP_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ys_q     <= '0;
            yd_q     <= '0;
            src_addr <= '0;
            dst_addr <= '0;
        end else begin
            if (load_rows) begin
                ys_q <= (2*COORD_W)'(y) * (2*COORD_W)'(src_stride);
                yd_q <= (2*COORD_W)'(y) * (2*COORD_W)'(dst_stride);
            end
            if (load_addr) begin
                src_addr <= src_base + src_off;
                dst_addr <= dst_base + dst_off;
            end
        end
    end

endmodule

// File: rtl/painterengine_gpu_block_sequencer.sv
// Block sequencer: walks an xcount x ycount region row-major in blocks of at
// most BLOCK_PIXELS, driving reader (FIFO1 src / FIFO2 dst), writer and
// rasterizer channels per block, with start/busy/done, abort and sticky errors.
// Ports: clock/reset, start/abort/mode and job configuration in; reader,
// writer and rasterizer request/status channels; busy, done pulse,
// error code and raw state out. Request strobes decode the registered state.
module painterengine_gpu_block_sequencer
    import painterengine_gpu_pkg::*;
#(
    parameter int unsigned COORD_W      = 16,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned BLOCK_PIXELS = 64,
    parameter int unsigned BPP_SHIFT    = 2
) (
    input  logic                 i_wire_clock,
    input  logic                 i_wire_reset,
    input  logic                 i_wire_start,
    input  logic                 i_wire_abort,
    input  logic [1:0]           i_wire_mode,
    input  logic [ADDR_W-1:0]    i_wire_src_address,
    input  logic [ADDR_W-1:0]    i_wire_dst_address,
    input  logic [COORD_W-1:0]   i_wire_src_stride,
    input  logic [COORD_W-1:0]   i_wire_dst_stride,
    input  logic [COORD_W-1:0]   i_wire_xcount,
    input  logic [COORD_W-1:0]   i_wire_ycount,
    output logic [ADDR_W-1:0]    o_wire_reader_address,
    output logic [COORD_W-1:0]   o_wire_reader_length,
    output logic                 o_wire_reader1_start,
    output logic                 o_wire_reader2_start,
    input  logic                 i_wire_reader_done,
    input  logic                 i_wire_reader_error,
    output logic [ADDR_W-1:0]    o_wire_writer_address,
    output logic [COORD_W-1:0]   o_wire_writer_length,
    output logic                 o_wire_writer_start,
    input  logic                 i_wire_writer_done,
    input  logic                 i_wire_writer_error,
    output logic [2*COORD_W-1:0] o_wire_rasterizer_xy,
    output logic                 o_wire_rasterizer_valid,
    input  logic                 i_wire_rasterizer_ready,
    output logic                 o_wire_busy,
    output logic                 o_wire_done,
    output logic [2:0]           o_wire_error_code,
    output logic [7:0]           o_wire_state
);

    state_t               state_q, state_d;
    mode_t                mode_q;
    err_t                 err_q, err_d;
    logic [ADDR_W-1:0]    src_base_q, dst_base_q, src_addr, dst_addr;
    logic [COORD_W-1:0]   src_stride_q, dst_stride_q, xcount_q, ycount_q;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d, k_q, k_d, len_q, len_d, rem;
    logic                 done_q, finish, load_cfg, load_rows, load_addr;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        x_d       = x_q;
        y_d       = y_q;
        k_d       = k_q;
        len_d     = len_q;
        finish    = 1'b0;
        load_cfg  = 1'b0;
        load_rows = 1'b0;
        load_addr = 1'b0;
        rem       = xcount_q - x_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_wire_start) begin
                    load_cfg = 1'b1;
                    x_d      = '0;
                    y_d      = '0;
                    k_d      = '0;
                    err_d    = ERR_NONE;
                    if (mode_t'(i_wire_mode) == MODE_ILLEGAL) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_MODE;
                        finish  = 1'b1;
                    end else if (i_wire_xcount == '0 || i_wire_ycount == '0) begin
                        state_d = ST_DONE;
                        finish  = 1'b1;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                // Row wrap; x/y are left untouched on the final row so the
                // outputs stay held in DONE.
                if (x_q == xcount_q) begin
                    if ((y_q + COORD_W'(1)) == ycount_q) begin
                        state_d = ST_DONE;
                        finish  = 1'b1;
                    end else begin
                        x_d     = '0;
                        y_d     = y_q + COORD_W'(1);
                        state_d = ST_ADDR0;
                    end
                end else begin
                    state_d = ST_ADDR0;
                end
            end
            ST_ADDR0: begin
                len_d     = (rem > COORD_W'(BLOCK_PIXELS)) ? COORD_W'(BLOCK_PIXELS) : rem;
                load_rows = 1'b1;
                state_d   = ST_ADDR1;
            end
            ST_ADDR1: begin
                load_addr = 1'b1;
                k_d       = '0;
                state_d   = (mode_q == MODE_RASTER) ? ST_GEN : ST_READ1;
            end
            ST_GEN: begin
                if (i_wire_rasterizer_ready) begin
                    if (k_q == len_q - COORD_W'(1)) begin
                        k_d     = '0;
                        state_d = ST_READ2;
                    end else begin
                        k_d = k_q + COORD_W'(1);
                    end
                end
            end
            ST_READ1: begin
                if (i_wire_reader_error) begin
                    err_d   = ERR_READER1;
                    state_d = ST_ERROR;
                    finish  = 1'b1;
                end else if (i_wire_reader_done) begin
                    state_d = (mode_q == MODE_COPY) ? ST_WRITE : ST_READ2;
                end
            end
            ST_READ2: begin
                if (i_wire_reader_error) begin
                    err_d   = ERR_READER2;
                    state_d = ST_ERROR;
                    finish  = 1'b1;
                end else if (i_wire_reader_done) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (i_wire_writer_error) begin
                    err_d   = ERR_WRITER;
                    state_d = ST_ERROR;
                    finish  = 1'b1;
                end else if (i_wire_writer_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                x_d     = x_q + len_q;
                state_d = ST_CHECK;
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_wire_abort && !is_idle_like(state_q)) begin
            state_d = ST_ERROR;
            err_d   = ERR_ABORT;
            finish  = 1'b1;
        end
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state_q      <= ST_IDLE;
            err_q        <= ERR_NONE;
            mode_q       <= MODE_BLEND;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            xcount_q     <= '0;
            ycount_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            k_q          <= '0;
            len_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            len_q   <= len_d;
            done_q  <= finish;
            if (load_cfg) begin
                mode_q       <= mode_t'(i_wire_mode);
                src_base_q   <= i_wire_src_address;
                dst_base_q   <= i_wire_dst_address;
                src_stride_q <= i_wire_src_stride;
                dst_stride_q <= i_wire_dst_stride;
                xcount_q     <= i_wire_xcount;
                ycount_q     <= i_wire_ycount;
            end
        end
    end

    painterengine_gpu_block_addr #(
        .COORD_W  (COORD_W),
        .ADDR_W   (ADDR_W),
        .BPP_SHIFT(BPP_SHIFT)
    ) u_addr (
        .clk       (i_wire_clock),
        .reset     (i_wire_reset),
        .load_rows (load_rows),
        .load_addr (load_addr),
        .y         (y_q),
        .x         (x_q),
        .src_stride(src_stride_q),
        .dst_stride(dst_stride_q),
        .src_base  (src_base_q),
        .dst_base  (dst_base_q),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr)
    );

    assign o_wire_reader_address   = (state_q == ST_READ2) ? dst_addr : src_addr;
    assign o_wire_reader_length    = len_q;
    assign o_wire_reader1_start    = (state_q == ST_READ1);
    assign o_wire_reader2_start    = (state_q == ST_READ2);
    assign o_wire_writer_address   = dst_addr;
    assign o_wire_writer_length    = len_q;
    assign o_wire_writer_start     = (state_q == ST_WRITE);
    assign o_wire_rasterizer_xy    = {y_q, x_q + k_q};
    assign o_wire_rasterizer_valid = (state_q == ST_GEN);
    assign o_wire_busy             = !is_idle_like(state_q);
    assign o_wire_done             = done_q;
    assign o_wire_error_code       = err_q;
    assign o_wire_state            = state_q;

endmodule

// File: tb/tb_painterengine_gpu_block_sequencer.sv
// Directed bench for the block sequencer: blend walk, empty/illegal jobs,
// rasterizer back-pressure, copy mode, reader error, abort and mid-job reset.
module tb_painterengine_gpu_block_sequencer;

    localparam int unsigned CW = 16;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [AW-1:0] src_a = '0, dst_a = '0;
    logic [CW-1:0] src_s = '0, dst_s = '0, xc = '0, yc = '0;
    logic          rdone = 1'b0, rerr = 1'b0, wdone = 1'b0, werr = 1'b0, ready = 1'b0;

    logic [AW-1:0]   r_addr, w_addr;
    logic [CW-1:0]   r_len, w_len;
    logic            r1s, r2s, ws, valid, busy, done;
    logic [2*CW-1:0] xy;
    logic [2:0]      err;
    logic [7:0]      state;

    int checks = 0, failures = 0;
    int r1_cnt = 0, r2_cnt = 0, w_cnt = 0, done_cnt = 0;
    int snap_a, snap_b;

    logic [AW-1:0] blk_src [4] = '{32'h1000, 32'h1100, 32'h1200, 32'h1300};
    logic [AW-1:0] blk_dst [4] = '{32'h8000, 32'h8100, 32'h8200, 32'h8300};
    logic [CW-1:0] blk_len [4] = '{16'd64, 16'd36, 16'd64, 16'd36};

    always #5 clk = ~clk;

    painterengine_gpu_block_sequencer #(
        .COORD_W     (CW),
        .ADDR_W      (AW),
        .BLOCK_PIXELS(64),
        .BPP_SHIFT   (2)
    ) dut (
        .i_wire_clock           (clk),
        .i_wire_reset           (reset),
        .i_wire_start           (start),
        .i_wire_abort           (abort),
        .i_wire_mode            (mode),
        .i_wire_src_address     (src_a),
        .i_wire_dst_address     (dst_a),
        .i_wire_src_stride      (src_s),
        .i_wire_dst_stride      (dst_s),
        .i_wire_xcount          (xc),
        .i_wire_ycount          (yc),
        .o_wire_reader_address  (r_addr),
        .o_wire_reader_length   (r_len),
        .o_wire_reader1_start   (r1s),
        .o_wire_reader2_start   (r2s),
        .i_wire_reader_done     (rdone),
        .i_wire_reader_error    (rerr),
        .o_wire_writer_address  (w_addr),
        .o_wire_writer_length   (w_len),
        .o_wire_writer_start    (ws),
        .i_wire_writer_done     (wdone),
        .i_wire_writer_error    (werr),
        .o_wire_rasterizer_xy   (xy),
        .o_wire_rasterizer_valid(valid),
        .i_wire_rasterizer_ready(ready),
        .o_wire_busy            (busy),
        .o_wire_done            (done),
        .o_wire_error_code      (err),
        .o_wire_state           (state)
    );

    always @(posedge clk) begin
        if (r1s)  r1_cnt   <= r1_cnt + 1;
        if (r2s)  r2_cnt   <= r2_cnt + 1;
        if (ws)   w_cnt    <= w_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return r1s;
            1:       return r2s;
            2:       return ws;
            3:       return valid;
            default: return done;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        int n = 0;
        while (!sig(sel) && n < 40) begin
            tick();
            n++;
        end
        check({tag, " seen"}, 64'(sig(sel)), 64'd1);
    endtask

    // Waits for a request, checks address/length, answers with a one-cycle
    // done and checks that the request drops right after.
    task automatic serve(input int sel, input logic [AW-1:0] addr, input logic [CW-1:0] len,
                         input string tag);
        wait_for(sel, tag);
        if (sel == 2) begin
            check({tag, " addr"}, 64'(w_addr), 64'(addr));
            check({tag, " len"},  64'(w_len),  64'(len));
            wdone = 1'b1;
        end else begin
            check({tag, " addr"}, 64'(r_addr), 64'(addr));
            check({tag, " len"},  64'(r_len),  64'(len));
            rdone = 1'b1;
        end
        tick();
        rdone = 1'b0;
        wdone = 1'b0;
        check({tag, " drop"}, 64'(sig(sel)), 64'd0);
    endtask

    task automatic start_job(input logic [1:0] m, input logic [AW-1:0] sa, input logic [AW-1:0] da,
                             input logic [CW-1:0] ss, input logic [CW-1:0] ds,
                             input logic [CW-1:0] x, input logic [CW-1:0] y);
        mode  = m;
        src_a = sa;
        dst_a = da;
        src_s = ss;
        dst_s = ds;
        xc    = x;
        yc    = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst state", 64'(state), 64'h00);
        check("rst busy",  64'(busy),  64'd0);
        check("rst done",  64'(done),  64'd0);
        check("rst starts", 64'({r1s, r2s, ws, valid}), 64'd0);
        check("rst raddr", 64'(r_addr), 64'd0);
        check("rst xy",    64'(xy),     64'd0);
        check("rst err",   64'(err),    64'd0);
        reset = 1'b0;
        tick();

        // Blend walk 100x2 with start latency
        snap_a = done_cnt;
        start_job(2'b00, 32'h1000, 32'h8000, 16'd128, 16'd128, 16'd100, 16'd2);
        check("lat busy",  64'(busy),  64'd1);
        check("lat state", 64'(state), 64'h01);
        tick();
        tick();
        check("lat r1 early", 64'(r1s), 64'd0);
        tick();
        check("lat r1",    64'(r1s),   64'd1);
        check("lat state READ1", 64'(state), 64'h05);
        for (int b = 0; b < 4; b++) begin
            serve(0, blk_src[b], blk_len[b], $sformatf("blend%0d r1", b));
            serve(1, blk_dst[b], blk_len[b], $sformatf("blend%0d r2", b));
            serve(2, blk_dst[b], blk_len[b], $sformatf("blend%0d w", b));
        end
        wait_for(4, "blend done");
        check("blend err",   64'(err),   64'd0);
        check("blend busy",  64'(busy),  64'd0);
        check("blend state", 64'(state), 64'h09);
        tick();
        tick();
        check("blend one done", 64'(done_cnt - snap_a), 64'd1);
        check("blend done low", 64'(done), 64'd0);

        // Empty region and illegal mode
        snap_a = r1_cnt + r2_cnt + w_cnt;
        start_job(2'b00, 32'h0, 32'h0, 16'd8, 16'd8, 16'd5, 16'd0);
        check("empty state", 64'(state), 64'h09);
        check("empty done",  64'(done),  64'd1);
        check("empty busy",  64'(busy),  64'd0);
        tick();
        check("empty done pulse", 64'(done), 64'd0);
        start_job(2'b11, 32'h0, 32'h0, 16'd8, 16'd8, 16'd5, 16'd1);
        check("illegal state", 64'(state), 64'h0A);
        check("illegal err",   64'(err),   64'd4);
        check("illegal done",  64'(done),  64'd1);
        tick();
        check("empty no starts", 64'(r1_cnt + r2_cnt + w_cnt - snap_a), 64'd0);

        // Rasterizer 3x1 with back-pressure on beat 1
        snap_a = r1_cnt;
        ready  = 1'b1;
        start_job(2'b01, 32'h0, 32'h2000, 16'd16, 16'd16, 16'd3, 16'd1);
        tick();
        tick();
        tick();
        check("gen valid", 64'(valid), 64'd1);
        check("gen xy0",   64'(xy),    64'h0);
        tick();
        check("gen xy1 a", 64'(xy), 64'h1);
        ready = 1'b0;
        tick();
        check("gen xy1 b", 64'(xy), 64'h1);
        tick();
        check("gen xy1 c", 64'(xy), 64'h1);
        ready = 1'b1;
        tick();
        check("gen xy2",   64'(xy),    64'h2);
        check("gen valid2", 64'(valid), 64'd1);
        tick();
        check("gen valid drop", 64'(valid), 64'd0);
        check("gen to READ2",   64'(state), 64'h06);
        serve(1, 32'h2000, 16'd3, "rast r2");
        serve(2, 32'h2000, 16'd3, "rast w");
        wait_for(4, "rast done");
        check("rast no r1", 64'(r1_cnt - snap_a), 64'd0);
        check("rast err",   64'(err), 64'd0);

        // Copy 64x1
        snap_b = r2_cnt;
        start_job(2'b10, 32'h4000, 32'h5000, 16'd64, 16'd64, 16'd64, 16'd1);
        serve(0, 32'h4000, 16'd64, "copy r1");
        serve(2, 32'h5000, 16'd64, "copy w");
        wait_for(4, "copy done");
        check("copy no r2", 64'(r2_cnt - snap_b), 64'd0);
        check("copy err",   64'(err), 64'd0);

        // Reader error in READ2, asserted together with done
        start_job(2'b00, 32'h100, 32'h200, 16'd8, 16'd8, 16'd4, 16'd1);
        serve(0, 32'h100, 16'd4, "err r1");
        wait_for(1, "err r2");
        rerr  = 1'b1;
        rdone = 1'b1;
        tick();
        rerr  = 1'b0;
        rdone = 1'b0;
        check("err starts", 64'({r1s, r2s, ws, valid}), 64'd0);
        check("err busy",   64'(busy),  64'd0);
        check("err code",   64'(err),   64'd2);
        check("err done",   64'(done),  64'd1);
        check("err state",  64'(state), 64'h0A);
        start_job(2'b00, 32'h100, 32'h200, 16'd8, 16'd8, 16'd4, 16'd1);
        check("restart code", 64'(err),  64'd0);
        check("restart busy", 64'(busy), 64'd1);

        // Abort during WRITE
        serve(0, 32'h100, 16'd4, "abort r1");
        serve(1, 32'h200, 16'd4, "abort r2");
        wait_for(2, "abort w");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort ws",    64'(ws),    64'd0);
        check("abort code",  64'(err),   64'd5);
        check("abort state", 64'(state), 64'h0A);
        check("abort busy",  64'(busy),  64'd0);

        // Reset mid-GEN
        ready = 1'b0;
        start_job(2'b01, 32'h0, 32'h3000, 16'd16, 16'd16, 16'd3, 16'd1);
        wait_for(3, "mid gen");
        reset = 1'b1;
        tick();
        check("mres state", 64'(state), 64'h00);
        check("mres valid", 64'(valid), 64'd0);
        check("mres busy",  64'(busy),  64'd0);
        check("mres err",   64'(err),   64'd0);
        check("mres waddr", 64'(w_addr), 64'd0);
        check("mres len",   64'({r_len, w_len}), 64'd0);
        check("mres xy",    64'(xy),    64'd0);
        check("mres done",  64'(done),  64'd0);
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
